// File: rtl/mcu_spi_pkg.sv
// ============================================================================
// Module   : mcu_spi_pkg
// Purpose  : Shared FSM encoding and default widths for the MCU SPI slave.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package mcu_spi_pkg;

  localparam int c_DEF_ADDR_W      = 7;
  localparam int c_DEF_DATA_W      = 16;
  localparam int c_DEF_RD_LAT      = 1;
  localparam int c_DEF_SYNC_STAGES = 2;

  // Position of the read/not-write flag inside the default command word.
  localparam int RNW_BIT = c_DEF_ADDR_W;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CMD  = 2'd1,
    ST_DATA = 2'd2
  } spi_state_e;

endpackage

`default_nettype wire

// File: rtl/mcu_spi_sync_edge.sv
// ============================================================================
// Module   : mcu_spi_sync_edge
// Purpose  : N-stage synchroniser with a change detector on the resolved level.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mcu_spi_sync_edge #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_d,
  output logic o_q,
  output logic o_edge
);

  logic [STAGES-1:0] r_sync;
  logic              r_prev;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync <= {STAGES{RST_VAL}};
      r_prev <= RST_VAL;
    end else begin
      r_sync[0] <= i_d;
      for (int i = 1; i < STAGES; i++) begin
        r_sync[i] <= r_sync[i-1];
      end
      r_prev <= r_sync[STAGES-1];
    end
  end

  assign o_q    = r_sync[STAGES-1];
  assign o_edge = r_sync[STAGES-1] ^ r_prev;

endmodule

`default_nettype wire

// File: rtl/mcu_spi_slave_regif.sv
// ============================================================================
// Module   : mcu_spi_slave_regif
// Purpose  : SPI mode-0 slave bridging MCU frames onto a register bus.
//            Define MCU_SPI_FRAME_STATS_EN to add frame/abort counters.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mcu_spi_slave_regif
  import mcu_spi_pkg::*;
#(
  parameter int ADDR_W      = c_DEF_ADDR_W,
  parameter int DATA_W      = c_DEF_DATA_W,
  parameter int RD_LAT      = c_DEF_RD_LAT,
  parameter int SYNC_STAGES = c_DEF_SYNC_STAGES
) (
  input  logic              aclk,
  input  logic              aresetn,
  input  logic              spi_sck_i,
  input  logic              spi_cs_n_i,
  input  logic              spi_mosi_i,
  output logic              spi_miso_o,
  output logic              spi_miso_t,
  output logic [ADDR_W-1:0] reg_addr,
  output logic              reg_wr_en,
  output logic [DATA_W-1:0] reg_wdata,
  output logic              reg_rd_en,
  input  logic [DATA_W-1:0] reg_rdata,
  output logic              busy,
  output logic              frame_abort
`ifdef MCU_SPI_FRAME_STATS_EN
  ,
  output logic [15:0]       stat_frames,
  output logic [15:0]       stat_aborts
`endif
);

  localparam int c_RNW_BIT  = ADDR_W;
  localparam int c_MAX_BITS = (ADDR_W + 1 > DATA_W) ? ADDR_W + 1 : DATA_W;
  localparam int c_CNT_W    = (c_MAX_BITS > 2) ? $clog2(c_MAX_BITS) : 1;
  localparam logic [c_CNT_W-1:0] c_CMD_LAST  = c_CNT_W'(ADDR_W);
  localparam logic [c_CNT_W-1:0] c_DATA_LAST = c_CNT_W'(DATA_W - 1);

  logic w_sck_q, w_sck_edge, w_cs_q, w_cs_edge;
  logic w_sck_rise, w_sck_fall, w_cs_rise, w_cs_fall;
  logic [SYNC_STAGES-1:0] r_mosi_sync;
  logic w_mosi;

  mcu_spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sck (
    .clk    (aclk),
    .rst_n  (aresetn),
    .i_d    (spi_sck_i),
    .o_q    (w_sck_q),
    .o_edge (w_sck_edge)
  );

  mcu_spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_cs (
    .clk    (aclk),
    .rst_n  (aresetn),
    .i_d    (spi_cs_n_i),
    .o_q    (w_cs_q),
    .o_edge (w_cs_edge)
  );

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_mosi_sync <= '0;
    end else begin
      r_mosi_sync[0] <= spi_mosi_i;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        r_mosi_sync[i] <= r_mosi_sync[i-1];
      end
    end
  end

  assign w_mosi     = r_mosi_sync[SYNC_STAGES-1];
  assign w_sck_rise = w_sck_edge &  w_sck_q;
  assign w_sck_fall = w_sck_edge & ~w_sck_q;
  assign w_cs_rise  = w_cs_edge  &  w_cs_q;
  assign w_cs_fall  = w_cs_edge  & ~w_cs_q;

  spi_state_e          r_state;
  logic [c_CNT_W-1:0]  r_cnt;
  logic [DATA_W-2:0]   r_rx;
  logic [DATA_W-1:0]   r_tx;
  logic                r_rnw;
  logic                r_inc;
  logic [RD_LAT-1:0]   r_rd_pipe;

  logic [c_CNT_W-1:0]  w_cnt_next;
  logic                w_word_done;
  logic [DATA_W-1:0]   w_rx_next;
  logic [DATA_W-1:0]   w_tx_src;
  logic                w_load;
  logic                w_frame_end;
  logic                w_abort;

  assign w_rx_next   = {r_rx, w_mosi};
  assign w_load      = r_rd_pipe[RD_LAT-1];
  assign w_tx_src    = w_load ? reg_rdata : r_tx;
  assign w_frame_end = w_cs_rise && (r_state != ST_IDLE);
  // A rise landing with CS release is counted first, so a completed word leaves 0.
  assign w_abort     = w_frame_end && (w_cnt_next != '0);

  always_comb begin
    w_word_done = 1'b0;
    w_cnt_next  = r_cnt;
    if (w_sck_rise && (r_state != ST_IDLE)) begin
      w_word_done = (r_state == ST_CMD) ? (r_cnt == c_CMD_LAST) : (r_cnt == c_DATA_LAST);
      w_cnt_next  = w_word_done ? '0 : r_cnt + 1'b1;
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_state     <= ST_IDLE;
      r_cnt       <= '0;
      r_rx        <= '0;
      r_tx        <= '0;
      r_rnw       <= 1'b0;
      r_inc       <= 1'b0;
      r_rd_pipe   <= '0;
      spi_miso_o  <= 1'b0;
      spi_miso_t  <= 1'b1;
      reg_addr    <= '0;
      reg_wr_en   <= 1'b0;
      reg_wdata   <= '0;
      reg_rd_en   <= 1'b0;
      busy        <= 1'b0;
      frame_abort <= 1'b0;
    end else begin
      reg_wr_en   <= 1'b0;
      reg_rd_en   <= 1'b0;
      frame_abort <= 1'b0;

      r_rd_pipe[0] <= reg_rd_en;
      for (int i = 1; i < RD_LAT; i++) begin
        r_rd_pipe[i] <= r_rd_pipe[i-1];
      end

      if (r_inc) begin
        reg_addr <= reg_addr + 1'b1;
        r_inc    <= 1'b0;
      end

      // Read data arriving on the same cycle as a fall is forwarded straight to MISO.
      if (w_sck_fall && (r_state == ST_DATA)) begin
        spi_miso_o <= r_rnw & w_tx_src[DATA_W-1];
        r_tx       <= {w_tx_src[DATA_W-2:0], 1'b0};
      end else if (w_load) begin
        r_tx <= reg_rdata;
      end

      case (r_state)
        ST_IDLE: begin
          if (w_cs_fall) begin
            r_state    <= ST_CMD;
            r_cnt      <= '0;
            busy       <= 1'b1;
            spi_miso_t <= 1'b0;
            spi_miso_o <= 1'b0;
          end
        end
        ST_CMD: begin
          r_cnt <= w_cnt_next;
          if (w_sck_rise) begin
            r_rx <= w_rx_next[DATA_W-2:0];
            if (w_word_done) begin
              reg_addr  <= w_rx_next[ADDR_W-1:0];
              r_rnw     <= w_rx_next[c_RNW_BIT];
              reg_rd_en <= w_rx_next[c_RNW_BIT];
              r_state   <= ST_DATA;
            end
          end
        end
        ST_DATA: begin
          r_cnt <= w_cnt_next;
          if (w_sck_rise) begin
            r_rx <= w_rx_next[DATA_W-2:0];
            if (w_word_done) begin
              if (r_rnw) begin
                reg_addr  <= reg_addr + 1'b1;
                reg_rd_en <= 1'b1;
              end else begin
                reg_wr_en <= 1'b1;
                reg_wdata <= w_rx_next;
                r_inc     <= 1'b1;
              end
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase

      if (w_frame_end) begin
        r_state     <= ST_IDLE;
        r_cnt       <= '0;
        busy        <= 1'b0;
        spi_miso_t  <= 1'b1;
        spi_miso_o  <= 1'b0;
        frame_abort <= w_abort;
      end
    end
  end

`ifdef MCU_SPI_FRAME_STATS_EN
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      stat_frames <= '0;
      stat_aborts <= '0;
    end else if (w_frame_end) begin
      if (w_abort) begin
        if (stat_aborts != 16'hFFFF) stat_aborts <= stat_aborts + 16'd1;
      end else begin
        if (stat_frames != 16'hFFFF) stat_frames <= stat_frames + 16'd1;
      end
    end
  end
`endif

endmodule

`default_nettype wire
